// File: rtl/syst_feeder.sv
// Operand feeder for a 4x4 systolic array: holds A/B, streams skewed west rows and north columns.
// Build option FEEDER_DBUF_EN: double-buffered operand store (write bank / read bank swap on start).
module syst_feeder (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        wr_sel,
    input  logic [3:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        start,
    output logic [15:0] w_row0,
    output logic [15:0] w_row1,
    output logic [15:0] w_row2,
    output logic [15:0] w_row3,
    output logic [15:0] n_col0,
    output logic [15:0] n_col1,
    output logic [15:0] n_col2,
    output logic [15:0] n_col3,
    output logic        arr_clr,
    output logic        busy,
    output logic        done
);
    localparam int LANES  = 4;
    localparam int T_LAST = 9;

    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} state_t;

    state_t                       state;
    logic [3:0]                   t;
    logic [LANES-1:0][15:0]       w_q, n_q, w_nxt, n_nxt;
    logic [15:0][15:0]            rd_a, rd_b;
    logic [3:0]                   tt;
    logic                         go;

    assign go = (state == IDLE) && start;

`ifdef FEEDER_DBUF_EN
    logic [1:0][15:0][15:0] a_mem, b_mem;
    logic                   wb, rb;

    // A write coincident with an accepted start lands in the old wb, which becomes rb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_mem <= '0;
            b_mem <= '0;
            wb    <= 1'b0;
            rb    <= 1'b0;
        end else begin
            if (wr_en) begin
                if (wr_sel) b_mem[wb][wr_addr] <= wr_data;
                else        a_mem[wb][wr_addr] <= wr_data;
            end
            if (go) begin
                rb <= wb;
                wb <= ~wb;
            end
        end
    end

    assign rd_a = a_mem[rb];
    assign rd_b = b_mem[rb];
`else
    logic [15:0][15:0] a_mem, b_mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_mem <= '0;
            b_mem <= '0;
        end else if (wr_en && state == IDLE) begin
            if (wr_sel) b_mem[wr_addr] <= wr_data;
            else        a_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_a = a_mem;
    assign rd_b = b_mem;
`endif

    // Lane values for the step about to be registered; lane i is skewed by i cycles.
    always_comb begin
        w_nxt = '0;
        n_nxt = '0;
        tt    = (state == STREAM) ? t + 4'd1 : 4'd0;
        for (int i = 0; i < LANES; i++) begin
            int k;
            k = int'(tt) - i;
            if (k >= 0 && k <= 3) begin
                w_nxt[i] = rd_a[4'(i * 4 + k)];
                n_nxt[i] = rd_b[4'(k * 4 + i)];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            t       <= 4'd0;
            w_q     <= '0;
            n_q     <= '0;
            arr_clr <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            arr_clr <= 1'b0;
            done    <= 1'b0;
            w_q     <= '0;
            n_q     <= '0;
            case (state)
                IDLE: if (go) begin
                    state   <= CLEAR;
                    arr_clr <= 1'b1;
                    busy    <= 1'b1;
                end
                CLEAR: begin
                    state <= STREAM;
                    t     <= 4'd0;
                    w_q   <= w_nxt;
                    n_q   <= n_nxt;
                end
                STREAM: begin
                    if (t == 4'(T_LAST)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        t     <= 4'd0;
                    end else begin
                        t   <= t + 4'd1;
                        w_q <= w_nxt;
                        n_q <= n_nxt;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign w_row0 = w_q[0];
    assign w_row1 = w_q[1];
    assign w_row2 = w_q[2];
    assign w_row3 = w_q[3];
    assign n_col0 = n_q[0];
    assign n_col1 = n_q[1];
    assign n_col2 = n_q[2];
    assign n_col3 = n_q[3];
endmodule

// File: tb/tb_syst_feeder.sv
// Bench for syst_feeder: randomized operands against a cycle-by-cycle model of the stream schedule.
module tb_syst_feeder;
    logic        clk = 1'b0;
    logic        rst, wr_en, wr_sel, start;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] w_row0, w_row1, w_row2, w_row3, n_col0, n_col1, n_col2, n_col3;
    logic        arr_clr, busy, done;

    int vecs = 0, errs = 0;

`ifdef FEEDER_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    // Model: two operand banks (only bank 0 used without double buffering).
    logic [15:0] ma[2][16], mb[2][16];
    int          wbm, rbm;

    syst_feeder dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start),
        .w_row0(w_row0), .w_row1(w_row1), .w_row2(w_row2), .w_row3(w_row3),
        .n_col0(n_col0), .n_col1(n_col1), .n_col2(n_col2), .n_col3(n_col3),
        .arr_clr(arr_clr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [130:0] obs();
        return {arr_clr, busy, done, w_row0, w_row1, w_row2, w_row3,
                n_col0, n_col1, n_col2, n_col3};
    endfunction

    function automatic void m_reset();
        for (int b = 0; b < 2; b++)
            for (int e = 0; e < 16; e++) begin
                ma[b][e] = '0;
                mb[b][e] = '0;
            end
        wbm = 0;
        rbm = 0;
    endfunction

    function automatic void m_write(bit busy_now, bit sel, int addr, logic [15:0] d);
        if (DBUF) begin
            if (sel) mb[wbm][addr] = d; else ma[wbm][addr] = d;
        end else if (!busy_now) begin
            if (sel) mb[0][addr] = d; else ma[0][addr] = d;
        end
    endfunction

    function automatic void m_start();
        if (DBUF) begin
            rbm = wbm;
            wbm = 1 - wbm;
        end else rbm = 0;
    endfunction

    // Expected outputs c cycles after the start edge (c = 13 is back in IDLE).
    function automatic logic [130:0] exp_at(int c);
        logic clr, bsy, dn;
        logic [15:0] w[4], n[4];
        clr = (c == 1);
        bsy = (c >= 1 && c <= 12);
        dn  = (c == 12);
        for (int i = 0; i < 4; i++) begin
            w[i] = '0;
            n[i] = '0;
            if (c >= 2 && c <= 11 && (c - 2 - i) >= 0 && (c - 2 - i) <= 3) begin
                w[i] = ma[rbm][i * 4 + (c - 2 - i)];
                n[i] = mb[rbm][(c - 2 - i) * 4 + i];
            end
        end
        return {clr, bsy, dn, w[0], w[1], w[2], w[3], n[0], n[1], n[2], n[3]};
    endfunction

    task automatic do_write(input bit sel, input int addr, input logic [15:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = d;
        m_write(1'b0, sel, addr, d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load(input int mode);
        for (int e = 0; e < 16; e++) begin
            case (mode)
                0: begin do_write(0, e, (e % 5 == 0) ? 16'd1 : 16'd0); do_write(1, e, 16'(e + 1)); end
                1: begin do_write(0, e, 16'(16 * (e / 4) + e % 4)); do_write(1, e, 16'($urandom)); end
                default: begin do_write(0, e, 16'($urandom)); do_write(1, e, 16'($urandom)); end
            endcase
        end
    endtask

    // Starts a stream from a negedge in IDLE and checks all outputs every cycle through the return to IDLE.
    task automatic run_stream(input string nm, input bit cw, input logic [15:0] cw_data,
                              input int inj_c, input int wr_c, input logic [15:0] wr_v);
        logic [130:0] e;
        start = 1'b1;
        if (cw) begin
            wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd0; wr_data = cw_data;
            m_write(1'b0, 1'b1, 0, cw_data);
        end
        m_start();
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            e = exp_at(c);
            vecs++;
            if (obs() !== e) begin
                errs++;
                $display("FAIL %s cyc%0d: got %h want %h", nm, c, obs(), e);
            end
            if (c == inj_c) start = 1'b1;
            if (c == wr_c) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = wr_v;
                m_write(1'b1, 1'b0, 0, wr_v);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        m_reset();
        repeat (3) @(negedge clk);
        vecs++;
        if (obs() !== 131'd0) begin errs++; $display("FAIL reset_hold: got %h want 0", obs()); end
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if (obs() !== 131'd0) begin errs++; $display("FAIL reset_idle: got %h want 0", obs()); end
        run_stream("reset_store_zero", 0, '0, 0, 0, '0);
    endtask

    task automatic test_identity();
        load(0);
        run_stream("identity", 0, '0, 0, 0, '0);
    endtask

    task automatic test_rows();
        load(1);
        run_stream("rows", 0, '0, 0, 0, '0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            load(2);
            run_stream("random", 0, '0, 0, 0, '0);
        end
    endtask

    task automatic test_back_to_back();
        run_stream("b2b_a", 0, '0, 0, 0, '0);
        run_stream("b2b_b", 0, '0, 0, 0, '0);
    endtask

    task automatic test_start_ignore();
        load(2);
        run_stream("start_ignore", 0, '0, 6, 0, '0);
        repeat (13) begin
            @(negedge clk);
            vecs++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errs++;
                $display("FAIL start_ignore_idle: got busy=%b done=%b want 0 0", busy, done);
            end
        end
    endtask

    task automatic test_reset_mid();
        load(2);
        start = 1'b1;
        m_start();
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start = 1'b0;
            vecs++;
            if (obs() !== exp_at(c)) begin
                errs++;
                $display("FAIL reset_mid_pre cyc%0d: got %h want %h", c, obs(), exp_at(c));
            end
        end
        rst = 1'b1;
        #1;
        vecs++;
        if (obs() !== 131'd0) begin errs++; $display("FAIL reset_mid_async: got %h want 0", obs()); end
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            vecs++;
            if (obs() !== 131'd0) begin errs++; $display("FAIL reset_mid_nodone: got %h want 0", obs()); end
        end
        run_stream("reset_mid_zero", 0, '0, 0, 0, '0);
    endtask

    task automatic test_coincident();
        load(2);
        run_stream("coincident", 1, 16'hBEEF, 0, 0, '0);
    endtask

    task automatic test_busy_write();
        load(2);
        run_stream("busy_write_cur", 0, '0, 0, 5, 16'h0005);
        run_stream("busy_write_next", 0, '0, 0, 0, '0);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_rows();
        test_random();
        test_back_to_back();
        test_start_ignore();
        test_coincident();
        test_busy_write();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
